// File: rtl/ub_loop_nest_ctrl_if.sv
// Control bundle between a loop-nest sequencer and the unified-buffer port it drives.
// UB_LOOP_CTRL_HALF_VARS_EN adds the halved iteration vector used for nearest-neighbour reads.
interface ub_loop_nest_ctrl_if #(
    parameter int WIDTH = 16
);
    logic                  start;
    logic                  stall;
    logic                  flush;
    logic                  en;
    logic [2:0][WIDTH-1:0] ctrl_vars;
    logic                  busy;
    logic                  done;
`ifdef UB_LOOP_CTRL_HALF_VARS_EN
    logic [2:0][WIDTH-1:0] ctrl_vars_half;

    modport master (output start, stall, flush,
                    input  en, ctrl_vars, ctrl_vars_half, busy, done);
    modport slave  (input  start, stall, flush,
                    output en, ctrl_vars, ctrl_vars_half, busy, done);
`else
    modport master (output start, stall, flush,
                    input  en, ctrl_vars, busy, done);
    modport slave  (input  start, stall, flush,
                    output en, ctrl_vars, busy, done);
`endif
endinterface

// File: rtl/ub_loop_nest_ctrl.sv
// Sequences a 3-deep loop nest (start delay + initiation interval) into en/ctrl_vars for a UB port.
// Optional UB_LOOP_CTRL_HALF_VARS_EN drives ctrl_vars_half = ctrl_vars >> 1.
module ub_loop_nest_ctrl #(
    parameter int WIDTH       = 16,
    parameter int EXT0        = 1,
    parameter int EXT1        = 128,
    parameter int EXT2        = 128,
    parameter int START_DELAY = 0,
    parameter int II          = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    ub_loop_nest_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DONE} state_t;

    localparam logic [WIDTH-1:0] E0_LAST = WIDTH'(EXT0 - 1);
    localparam logic [WIDTH-1:0] E1_LAST = WIDTH'(EXT1 - 1);
    localparam logic [WIDTH-1:0] E2_LAST = WIDTH'(EXT2 - 1);
    localparam logic [WIDTH-1:0] II_LAST = WIDTH'(II - 1);
    localparam logic [WIDTH-1:0] SD_LAST = WIDTH'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      delay_cnt_q, delay_cnt_d;
    logic [WIDTH-1:0]      ii_cnt_q, ii_cnt_d;
    logic [2:0][WIDTH-1:0] vars_q, vars_d;
    logic                  en_int;
    logic                  wrap0, wrap1, wrap2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            delay_cnt_q <= '0;
            ii_cnt_q    <= '0;
            vars_q      <= '0;
        end else begin
            state_q     <= state_d;
            delay_cnt_q <= delay_cnt_d;
            ii_cnt_q    <= ii_cnt_d;
            vars_q      <= vars_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        ii_cnt_d    = ii_cnt_q;
        vars_d      = vars_q;
        en_int      = (state_q == S_RUN) && (ii_cnt_q == '0) && !bus.stall;
        wrap0       = (vars_q[0] == E0_LAST);
        wrap1       = (vars_q[1] == E1_LAST);
        wrap2       = (vars_q[2] == E2_LAST);

        if (bus.flush) begin
            state_d     = S_IDLE;
            delay_cnt_d = '0;
            ii_cnt_d    = '0;
            vars_d      = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    delay_cnt_d = '0;
                    ii_cnt_d    = '0;
                    vars_d      = '0;
                    if (bus.start) begin
                        state_d = (START_DELAY > 0) ? S_DELAY : S_RUN;
                    end
                end
                S_DELAY: begin
                    if (!bus.stall) begin
                        if (delay_cnt_q == SD_LAST) begin
                            delay_cnt_d = '0;
                            state_d     = S_RUN;
                        end else begin
                            delay_cnt_d = delay_cnt_q + ONE;
                        end
                    end
                end
                S_RUN: begin
                    if (!bus.stall) begin
                        ii_cnt_d = (ii_cnt_q == II_LAST) ? '0 : ii_cnt_q + ONE;
                    end
                    if (en_int) begin
                        if (wrap0 && wrap1 && wrap2) begin
                            state_d  = S_DONE;
                            ii_cnt_d = '0;
                            vars_d   = '0;
                        end else begin
                            // Odometer: each loop carries into the one outside it on wrap.
                            vars_d[2] = wrap2 ? '0 : vars_q[2] + ONE;
                            if (wrap2) begin
                                vars_d[1] = wrap1 ? '0 : vars_q[1] + ONE;
                            end
                            if (wrap2 && wrap1) begin
                                vars_d[0] = wrap0 ? '0 : vars_q[0] + ONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.en        = en_int;
    assign bus.ctrl_vars = vars_q;
    assign bus.busy      = (state_q == S_DELAY) || (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);

`ifdef UB_LOOP_CTRL_HALF_VARS_EN
    for (genvar gi = 0; gi < 3; gi++) begin : g_half
        assign bus.ctrl_vars_half[gi] = {1'b0, vars_q[gi][WIDTH-1:1]};
    end
`endif

endmodule

// File: tb/tb_ub_loop_nest_ctrl.sv
// Directed bench for ub_loop_nest_ctrl: default domain, delayed/II-spaced nest, stall, flush, reset.
module tb_ub_loop_nest_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    int   total = 0;
    int   bad   = 0;

    ub_loop_nest_ctrl_if #(.WIDTH(16)) bus_a ();
    ub_loop_nest_ctrl_if #(.WIDTH(16)) bus_b ();
    ub_loop_nest_ctrl_if #(.WIDTH(16)) bus_c ();

    ub_loop_nest_ctrl #(.WIDTH(16), .EXT0(1), .EXT1(128), .EXT2(128), .START_DELAY(0), .II(1))
        u_a (.clk(clk), .rst_n(rst_a), .bus(bus_a));
    ub_loop_nest_ctrl #(.WIDTH(16), .EXT0(2), .EXT1(3), .EXT2(4), .START_DELAY(5), .II(3))
        u_b (.clk(clk), .rst_n(rst_b), .bus(bus_b));
    ub_loop_nest_ctrl #(.WIDTH(16), .EXT0(1), .EXT1(2), .EXT2(2), .START_DELAY(0), .II(1))
        u_c (.clk(clk), .rst_n(rst_c), .bus(bus_c));

`ifdef UB_LOOP_CTRL_HALF_VARS_EN
    logic rst_d;
    ub_loop_nest_ctrl_if #(.WIDTH(16)) bus_d ();
    ub_loop_nest_ctrl #(.WIDTH(16), .EXT0(1), .EXT1(4), .EXT2(4), .START_DELAY(0), .II(1))
        u_d (.clk(clk), .rst_n(rst_d), .bus(bus_d));
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ctrl_vars packs index 0 in the low slice.
    function automatic logic [63:0] pk(input int a0, input int a1, input int a2);
        return {16'h0, a2[15:0], a1[15:0], a0[15:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    bit exp_en_s1 [10] = '{1, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    int exp_v1_s1 [8]  = '{0, 0, 0, 0, 0, 0, 1, 1};
    int exp_v2_s1 [8]  = '{0, 1, 1, 1, 1, 1, 0, 1};
    bit exp_en_s2 [7]  = '{1, 1, 1, 0, 1, 0, 0};
    int exp_v1_s2 [5]  = '{0, 0, 1, 1, 1};
    int exp_v2_s2 [5]  = '{0, 1, 0, 1, 1};

    initial begin
        int en_cnt;
        int done_cnt;
        int k;
        logic exp_en;

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        bus_a.start = 1'b0; bus_a.stall = 1'b0; bus_a.flush = 1'b0;
        bus_b.start = 1'b0; bus_b.stall = 1'b0; bus_b.flush = 1'b0;
        bus_c.start = 1'b0; bus_c.stall = 1'b0; bus_c.flush = 1'b0;
`ifdef UB_LOOP_CTRL_HALF_VARS_EN
        rst_d = 1'b0;
        bus_d.start = 1'b0; bus_d.stall = 1'b0; bus_d.flush = 1'b0;
`endif
        cyc(); cyc();
        chk("rst_a_en", bus_a.en, 0);
        chk("rst_a_busy", bus_a.busy, 0);
        chk("rst_a_done", bus_a.done, 0);
        chk("rst_a_vars", bus_a.ctrl_vars, 0);
        chk("rst_b_busy", bus_b.busy, 0);
        chk("rst_c_vars", bus_c.ctrl_vars, 0);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
`ifdef UB_LOOP_CTRL_HALF_VARS_EN
        rst_d = 1'b1;
`endif
        repeat (7) cyc();

        // Default domain: full 1x128x128 traversal, one stray start while busy.
        bus_a.start = 1'b1; #1;
        chk("a_en_start_cycle", bus_a.en, 0);
        for (int i = 0; i < 16384; i++) begin
            cyc();
            bus_a.start = (i == 100); #1;
            chk("a_en", bus_a.en, 1);
            chk("a_vars", bus_a.ctrl_vars, pk(0, i / 128, i % 128));
            if (i == 0) chk("a_busy_first", bus_a.busy, 1);
        end
        cyc(); bus_a.start = 1'b0; #1;
        chk("a_done", bus_a.done, 1);
        chk("a_busy_done", bus_a.busy, 0);
        chk("a_en_done", bus_a.en, 0);
        chk("a_vars_done", bus_a.ctrl_vars, 0);
        cyc(); #1;
        chk("a_done_once", bus_a.done, 0);
        chk("a_busy_after", bus_a.busy, 0);
        chk("a_en_after", bus_a.en, 0);

        // Flush at the 50th en, then restart from the origin.
        bus_a.start = 1'b1; #1;
        for (int i = 0; i < 50; i++) begin
            cyc();
            bus_a.start = 1'b0;
            bus_a.flush = (i == 49); #1;
            chk("fl_en", bus_a.en, 1);
            chk("fl_vars", bus_a.ctrl_vars, pk(0, 0, i));
        end
        cyc(); bus_a.flush = 1'b0; #1;
        chk("fl_en_after", bus_a.en, 0);
        chk("fl_busy_after", bus_a.busy, 0);
        chk("fl_vars_after", bus_a.ctrl_vars, 0);
        chk("fl_done_after", bus_a.done, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("fl_no_done", bus_a.done, 0);
            chk("fl_no_en", bus_a.en, 0);
        end
        bus_a.start = 1'b1; #1;
        cyc(); bus_a.start = 1'b0; #1;
        chk("fl_restart_en", bus_a.en, 1);
        chk("fl_restart_vars", bus_a.ctrl_vars, 0);
        cyc(); #1;
        chk("fl_restart_vars1", bus_a.ctrl_vars, pk(0, 0, 1));
        bus_a.flush = 1'b1; #1;
        cyc(); bus_a.flush = 1'b0; #1;
        chk("fl2_busy", bus_a.busy, 0);

        // EXT=(2,3,4), START_DELAY=5, II=3.
        bus_b.start = 1'b1; #1;
        for (int n = 1; n <= 80; n++) begin
            cyc();
            bus_b.start = (n == 20); #1;
            k = (n - 6) / 3;
            exp_en = (n >= 6) && ((n - 6) % 3 == 0) && (k < 24);
            chk("b_en", bus_b.en, exp_en);
            if (exp_en) chk("b_vars", bus_b.ctrl_vars, pk(k / 12, (k / 4) % 3, k % 4));
            chk("b_busy", bus_b.busy, (n <= 75));
            chk("b_done", bus_b.done, (n == 76));
        end

        // Asynchronous reset in DELAY, then a full run with starts while busy.
        bus_b.start = 1'b1; #1;
        cyc(); bus_b.start = 1'b0; #1;
        chk("b_busy_delay", bus_b.busy, 1);
        cyc(); #2;
        rst_b = 1'b0; #1;
        chk("b_rst_busy", bus_b.busy, 0);
        chk("b_rst_en", bus_b.en, 0);
        chk("b_rst_done", bus_b.done, 0);
        chk("b_rst_vars", bus_b.ctrl_vars, 0);
        cyc(); rst_b = 1'b1; #1;
        chk("b_rst_no_done", bus_b.done, 0);
        en_cnt = 0;
        done_cnt = 0;
        bus_b.start = 1'b1; #1;
        for (int n = 1; n <= 85; n++) begin
            cyc();
            bus_b.start = (n == 3) || (n == 40) || (n == 74); #1;
            if (bus_b.en === 1'b1) en_cnt++;
            if (bus_b.done === 1'b1) done_cnt++;
        end
        bus_b.start = 1'b0;
        chk("b_en_count", en_cnt, 24);
        chk("b_done_count", done_cnt, 1);

        // EXT=(1,2,2): 4-cycle stall on the 2nd iteration.
        bus_c.start = 1'b1; #1;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            bus_c.start = 1'b0;
            bus_c.stall = (n >= 2) && (n <= 5); #1;
            chk("c_en", bus_c.en, exp_en_s1[n-1]);
            if (n <= 8) begin
                chk("c_vars", bus_c.ctrl_vars, pk(0, exp_v1_s1[n-1], exp_v2_s1[n-1]));
                chk("c_busy", bus_c.busy, 1);
            end
            chk("c_done", bus_c.done, (n == 9));
        end

        // Stall coinciding with the last iteration keeps RUN.
        bus_c.start = 1'b1; #1;
        for (int n = 1; n <= 7; n++) begin
            cyc();
            bus_c.start = 1'b0;
            bus_c.stall = (n == 4); #1;
            chk("c2_en", bus_c.en, exp_en_s2[n-1]);
            if (n <= 5) begin
                chk("c2_vars", bus_c.ctrl_vars, pk(0, exp_v1_s2[n-1], exp_v2_s2[n-1]));
                chk("c2_busy", bus_c.busy, 1);
            end
            chk("c2_done", bus_c.done, (n == 6));
        end
        bus_c.stall = 1'b0;

`ifdef UB_LOOP_CTRL_HALF_VARS_EN
        bus_d.start = 1'b1; #1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            bus_d.start = 1'b0; #1;
            chk("d_vars", bus_d.ctrl_vars, pk(0, i / 4, i % 4));
            if (i == 14) chk("d_half_0_3_2", bus_d.ctrl_vars_half, pk(0, 1, 1));
            if (i == 7) chk("d_half_0_1_3", bus_d.ctrl_vars_half, pk(0, 0, 1));
        end
        cyc(); #1;
        chk("d_half_done", bus_d.ctrl_vars_half, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
